// File: rtl/sb_rx_packet_sequencer_pkg.sv
// Shared types and constants for the sideband RX packet sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sb_rx_pkg;

  localparam logic [4:0] OPC_MSG_NO_DATA   = 5'b10010;
  localparam logic [4:0] OPC_MSG_WITH_DATA = 5'b11011;

  // Header parity bit (covers header bits [61:0]) and payload parity bit
  // (carried in the header, covers all 64 payload bits).
  localparam int CP_BIT = 62;
  localparam int DP_BIT = 63;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DATA = 2'd1,
    DROP_DATA = 2'd2
  } sb_rx_seq_state_e;

endpackage

// File: rtl/sb_rx_packet_sequencer_if.sv
// Word stream from the deserializer and strobes/bus toward the RX decoder.
// Latency: n/a (wiring only).
// Backpressure: none; every valid word is consumed the cycle it is presented.
interface sb_rx_packet_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             i_flush;
  logic             i_word_valid;
  logic [63:0]      i_word;
  logic [63:0]      o_word;
  logic             o_header_is_valid_on_bus;
  logic             o_data_enable;
  logic             o_msg_done;
  logic             o_unsupported_err;
  logic             o_parity_err;
  logic             o_timeout_err;
  logic [CNT_W-1:0] o_msg_count;

  // Deserializer side: drives words and flush, observes the decoder bus.
  modport master (
    output i_flush, i_word_valid, i_word,
    input  o_word, o_header_is_valid_on_bus, o_data_enable, o_msg_done,
           o_unsupported_err, o_parity_err, o_timeout_err, o_msg_count
  );

  // Sequencer side.
  modport slave (
    input  i_flush, i_word_valid, i_word,
    output o_word, o_header_is_valid_on_bus, o_data_enable, o_msg_done,
           o_unsupported_err, o_parity_err, o_timeout_err, o_msg_count
  );
endinterface

// File: rtl/sb_rx_packet_sequencer_timeout_cnt.sv
// Loadable down-counter used to bound the wait for a payload word.
// Latency: load/decrement take effect at the next edge; expire is combinational.
// Backpressure: none.
module sb_rx_timeout_cnt #(
  parameter int W = 6
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         expire
);

  logic [W-1:0] cnt_q;

  // Load has priority; decrement stops at zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  // A decrement taken this cycle would bring the counter to zero.
  assign expire = (cnt_q <= W'(1));

endmodule

// File: rtl/sb_rx_packet_sequencer.sv
// Classifies deserialized words as header/payload and strobes the RX decoder; SB_RX_PARITY_CHECK_EN adds CP/DP checks.
// Latency: word and its strobes/errors are registered, visible one cycle after the word.
// Backpressure: none; accepts a valid word every cycle, i_flush aborts to IDLE.
module sb_rx_packet_sequencer
  import sb_rx_pkg::*;
#(
  parameter int DATA_TIMEOUT = 32,
  parameter int CNT_W        = 16
) (
  input logic                      i_clk,
  input logic                      i_rst_n,
  sb_rx_packet_sequencer_if.slave  bus
);

  localparam int TO_W = (DATA_TIMEOUT < 2) ? 1 : $clog2(DATA_TIMEOUT + 1);

  sb_rx_seq_state_e state_q, state_d;
  logic [4:0] opc;
  logic hdr_d, data_en_d, done_d, unsup_d, par_d, to_d;
  logic word_ld, cnt_inc, to_load, to_dec, to_expire;
  logic cp_ok, dp_ok;

  assign opc = bus.i_word[4:0];

`ifdef SB_RX_PARITY_CHECK_EN
  logic dp_q;

  // Capture DP from every word seen in IDLE; only the with-data header's copy is ever used.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dp_q <= 1'b0;
    end else if ((state_q == IDLE) && bus.i_word_valid && !bus.i_flush) begin
      dp_q <= bus.i_word[DP_BIT];
    end
  end

  assign cp_ok = ((^bus.i_word[CP_BIT-1:0]) == bus.i_word[CP_BIT]);
  assign dp_ok = ((^bus.i_word) == dp_q);
`else
  assign cp_ok = 1'b1;
  assign dp_ok = 1'b1;
`endif

  sb_rx_timeout_cnt #(.W(TO_W)) u_timeout (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .load     (to_load),
    .load_val (TO_W'(DATA_TIMEOUT)),
    .dec      (to_dec),
    .expire   (to_expire)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state and pulse decisions; flush overrides everything and emits nothing.
  always_comb begin
    state_d   = state_q;
    hdr_d     = 1'b0;
    data_en_d = 1'b0;
    done_d    = 1'b0;
    unsup_d   = 1'b0;
    par_d     = 1'b0;
    to_d      = 1'b0;
    cnt_inc   = 1'b0;
    to_load   = 1'b0;
    to_dec    = 1'b0;
    word_ld   = bus.i_word_valid && !bus.i_flush;
    if (bus.i_flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.i_word_valid) begin
            if ((opc != OPC_MSG_NO_DATA) && (opc != OPC_MSG_WITH_DATA)) begin
              unsup_d = 1'b1;
            end else if (!cp_ok) begin
              par_d = 1'b1;
              if (opc == OPC_MSG_WITH_DATA) begin
                state_d = DROP_DATA;
                to_load = 1'b1;
              end
            end else if (opc == OPC_MSG_NO_DATA) begin
              hdr_d   = 1'b1;
              done_d  = 1'b1;
              cnt_inc = 1'b1;
            end else begin
              hdr_d   = 1'b1;
              to_load = 1'b1;
              state_d = WAIT_DATA;
            end
          end
        end
        WAIT_DATA, DROP_DATA: begin
          if (bus.i_word_valid) begin
            state_d = IDLE;
            if (state_q == WAIT_DATA) begin
              if (dp_ok) begin
                data_en_d = 1'b1;
                done_d    = 1'b1;
                cnt_inc   = 1'b1;
              end else begin
                par_d = 1'b1;
              end
            end
          end else begin
            to_dec = 1'b1;
            if (to_expire) begin
              to_d    = 1'b1;
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Registered decoder bus, pulses and saturating message counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus.o_word                   <= '0;
      bus.o_header_is_valid_on_bus <= 1'b0;
      bus.o_data_enable            <= 1'b0;
      bus.o_msg_done               <= 1'b0;
      bus.o_unsupported_err        <= 1'b0;
      bus.o_parity_err             <= 1'b0;
      bus.o_timeout_err            <= 1'b0;
      bus.o_msg_count              <= '0;
    end else begin
      if (word_ld) bus.o_word <= bus.i_word;
      bus.o_header_is_valid_on_bus <= hdr_d;
      bus.o_data_enable            <= data_en_d;
      bus.o_msg_done               <= done_d;
      bus.o_unsupported_err        <= unsup_d;
      bus.o_parity_err             <= par_d;
      bus.o_timeout_err            <= to_d;
      if (cnt_inc && (bus.o_msg_count != {CNT_W{1'b1}})) begin
        bus.o_msg_count <= bus.o_msg_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sb_rx_packet_sequencer.sv
// Randomized and directed bench for sb_rx_packet_sequencer against a transaction-level model.
// Latency: expects registered outputs one cycle after each presented word.
// Backpressure: drives a word (or idle) every cycle; flush injected at random.
module tb_sb_rx_packet_sequencer;
  import sb_rx_pkg::*;

  localparam int DATA_TIMEOUT = 32;
  localparam int CNT_W        = 4;
`ifdef SB_RX_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int VW = CNT_W + 70;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  sb_rx_packet_sequencer_if #(.CNT_W(CNT_W)) bus ();

  sb_rx_packet_sequencer #(.DATA_TIMEOUT(DATA_TIMEOUT), .CNT_W(CNT_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: mode 0 = between messages, 1 = expecting payload, 2 = discarding payload.
  // A pending payload times out at an absolute cycle number (header cycle + DATA_TIMEOUT).
  int               m_mode = 0;
  int               m_cyc = 0;
  int               m_deadline = 0;
  bit               m_dp = 1'b0;
  // e_flags: {header, data_enable, msg_done, unsupported, parity, timeout}
  logic [5:0]       e_flags = '0;
  logic [63:0]      e_word = '0;
  logic [CNT_W-1:0] e_count = '0;

  function automatic logic [VW-1:0] obs();
    return {bus.o_msg_count, bus.o_word, bus.o_header_is_valid_on_bus, bus.o_data_enable,
            bus.o_msg_done, bus.o_unsupported_err, bus.o_parity_err, bus.o_timeout_err};
  endfunction

  function automatic logic [VW-1:0] expv();
    return {e_count, e_word, e_flags};
  endfunction

  function automatic logic [63:0] mk_hdr(input logic [4:0] op, input bit bad_cp, input bit dp);
    logic [63:0] w;
    w = {$urandom, $urandom};
    w[4:0] = op;
    w[63] = dp;
    w[62] = (^w[61:0]) ^ bad_cp;
    return w;
  endfunction

  task automatic model_reset();
    m_mode = 0; e_flags = '0; e_word = '0; e_count = '0;
  endtask

  task automatic model_count();
    if (e_count != {CNT_W{1'b1}}) e_count = e_count + 1'b1;
  endtask

  task automatic model_step(input bit f, input bit v, input logic [63:0] w);
    m_cyc++;
    e_flags = '0;
    if (f) begin
      m_mode = 0;
    end else if (m_mode != 0) begin
      if (v) begin
        e_word = w;
        if (m_mode == 1) begin
          if (!PAR_EN || ((^w) == m_dp)) begin e_flags = 6'b011000; model_count(); end
          else e_flags = 6'b000010;
        end
        m_mode = 0;
      end else if (m_cyc == m_deadline) begin
        e_flags = 6'b000001;
        m_mode = 0;
      end
    end else if (v) begin
      e_word = w;
      if (w[4:0] != 5'h12 && w[4:0] != 5'h1B) begin
        e_flags = 6'b000100;
      end else if (PAR_EN && ((^w[61:0]) != w[62])) begin
        e_flags = 6'b000010;
        if (w[4:0] == 5'h1B) begin m_mode = 2; m_deadline = m_cyc + DATA_TIMEOUT; end
      end else if (w[4:0] == 5'h12) begin
        e_flags = 6'b101000;
        model_count();
      end else begin
        e_flags = 6'b100000;
        m_mode = 1; m_dp = w[63]; m_deadline = m_cyc + DATA_TIMEOUT;
      end
    end
  endtask

  task automatic drive(input bit f, input bit v, input logic [63:0] w);
    bus.i_flush = f; bus.i_word_valid = v; bus.i_word = w;
    @(posedge clk);
    model_step(f, v, w);
    #1;
  endtask

  task automatic test_reset();
    bus.i_flush = 1'b0; bus.i_word_valid = 1'b0; bus.i_word = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    n_cmp++;
    if (obs() !== {VW{1'b0}}) begin
      n_bad++; $display("FAIL reset: got %h want 0", obs());
    end
    rst_n = 1'b1;
  endtask

  task automatic test_no_data();
    logic [63:0] seq [2];
    seq[0] = 64'h0000_0000_0000_0012; seq[1] = '0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, (i == 0), seq[i]);
      n_cmp++;
      if (obs() !== expv()) begin n_bad++; $display("FAIL no_data[%0d]: got %h want %h", i, obs(), expv()); end
    end
    n_cmp++;
    if (bus.o_msg_count !== CNT_W'(1)) begin n_bad++; $display("FAIL no_data_count: got %0d want 1", bus.o_msg_count); end
  endtask

  task automatic test_with_data();
    for (int i = 0; i < 6; i++) begin
      if (i == 0)      drive(1'b0, 1'b1, 64'h0000_0000_0000_001B);
      else if (i == 4) drive(1'b0, 1'b1, 64'h0);
      else             drive(1'b0, 1'b0, 64'hFFFF);
      n_cmp++;
      if (obs() !== expv()) begin n_bad++; $display("FAIL with_data[%0d]: got %h want %h", i, obs(), expv()); end
    end
  endtask

  task automatic test_unsupported();
    for (int i = 0; i < 3; i++) begin
      if (i == 0)      drive(1'b0, 1'b1, 64'h0000_0000_0000_0007);
      else if (i == 1) drive(1'b0, 1'b1, 64'h0000_0000_0000_0012);
      else             drive(1'b0, 1'b0, '0);
      n_cmp++;
      if (obs() !== expv()) begin n_bad++; $display("FAIL unsupported[%0d]: got %h want %h", i, obs(), expv()); end
    end
  endtask

  // idle_n idle cycles after a with-data header, then a no-data header.
  task automatic test_timeout(input int idle_n);
    drive(1'b0, 1'b1, mk_hdr(5'h1B, 1'b0, 1'b0));
    for (int i = 0; i <= idle_n + 1; i++) begin
      if (i < idle_n)       drive(1'b0, 1'b0, '0);
      else if (i == idle_n) drive(1'b0, 1'b1, mk_hdr(5'h12, 1'b0, 1'b0));
      else                  drive(1'b0, 1'b0, '0);
      n_cmp++;
      if (obs() !== expv()) begin n_bad++; $display("FAIL timeout%0d[%0d]: got %h want %h", idle_n, i, obs(), expv()); end
    end
  endtask

  task automatic test_parity();
    logic [63:0] w;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: drive(1'b0, 1'b1, mk_hdr(5'h1B, 1'b1, 1'b0));
        1: drive(1'b0, 1'b1, 64'h0000_0000_0000_0012);
        2: drive(1'b0, 1'b1, mk_hdr(5'h1B, 1'b0, 1'b1));
        3: begin w = {$urandom, $urandom}; w[0] = ~(^w[63:1]); drive(1'b0, 1'b1, w); end
        4: drive(1'b0, 1'b1, mk_hdr(5'h12, 1'b1, 1'b0));
        default: drive(1'b0, 1'b0, '0);
      endcase
      n_cmp++;
      if (obs() !== expv()) begin n_bad++; $display("FAIL parity[%0d]: got %h want %h", i, obs(), expv()); end
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: drive(1'b0, 1'b1, mk_hdr(5'h1B, 1'b0, 1'b0));
        1: drive(1'b1, 1'b1, 64'h0);
        2: drive(1'b0, 1'b1, 64'h0000_0000_0000_0012);
        default: drive(1'b0, 1'b0, '0);
      endcase
      n_cmp++;
      if (obs() !== expv()) begin n_bad++; $display("FAIL flush[%0d]: got %h want %h", i, obs(), expv()); end
    end
  endtask

  task automatic test_reset_mid_packet();
    drive(1'b0, 1'b1, mk_hdr(5'h1B, 1'b0, 1'b0));
    rst_n = 1'b0;
    #2;
    model_reset();
    n_cmp++;
    if (obs() !== {VW{1'b0}}) begin n_bad++; $display("FAIL reset_mid: got %h want 0", obs()); end
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 64'h0000_0000_0000_0012);
    n_cmp++;
    if (obs() !== expv()) begin n_bad++; $display("FAIL reset_mid_next: got %h want %h", obs(), expv()); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b1, mk_hdr(5'h12, 1'b0, $urandom_range(0, 1)));
      n_cmp++;
      if (obs() !== expv()) begin n_bad++; $display("FAIL saturate[%0d]: got %h want %h", i, obs(), expv()); end
    end
    n_cmp++;
    if (bus.o_msg_count !== {CNT_W{1'b1}}) begin n_bad++; $display("FAIL saturate_final: got %0d want all-ones", bus.o_msg_count); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] w;
    int kind, idle_run;
    bit f, v;
    idle_run = 0;
    for (int i = 0; i < 1500; i++) begin
      f = 1'b0; v = 1'b0; w = {$urandom, $urandom};
      if (idle_run > 0) begin
        idle_run--;
      end else begin
        kind = $urandom_range(0, 19);
        v = (kind != 19);
        f = ($urandom_range(0, 29) == 0);
        if (kind <= 5)       w = mk_hdr(5'h1B, ($urandom_range(0, 5) == 0), $urandom_range(0, 1));
        else if (kind <= 9)  w = mk_hdr(5'h12, ($urandom_range(0, 5) == 0), $urandom_range(0, 1));
        else if (kind == 10) w[4:0] = 5'($urandom_range(0, 31));
        else if (kind == 19) idle_run = $urandom_range(20, 40);
      end
      drive(f, v, w);
      n_cmp++;
      if (obs() !== expv()) begin n_bad++; $display("FAIL back_to_back[%0d]: got %h want %h", i, obs(), expv()); end
    end
  endtask

  initial begin
    test_reset();
    test_no_data();
    test_with_data();
    test_unsupported();
    test_timeout(DATA_TIMEOUT);
    test_timeout(DATA_TIMEOUT - 1);
    test_parity();
    test_flush();
    test_reset_mid_packet();
    test_saturation();
    test_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
